// File: rtl/ex_pipe_unit_pkg.sv
// Shared CPU definitions for the execute stage: ALU operation codes, flag
// bit positions and execute-unit FSM states.
package ex_pipe_unit_pkg;

  localparam int unsigned BYTE = 8;

  // Bit positions inside the {N,V,Z,C} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [3:0] {
    ADC, SBC, AND, ORA, EOR, ASL, LSR, ROL, ROR, INC, DEC, CMP, BIT, PASSB
  } alu_op_t;

  typedef enum logic {
    IDLE,
    BCD
  } ex_state_t;

  function automatic logic is_arith(alu_op_t op);
    return (op == ADC) || (op == SBC);
  endfunction

endpackage

// File: rtl/ex_pipe_unit_bcd_nibble.sv
// Combinational 4-bit decimal add/subtract step with carry in/out.
// For subtraction the caller supplies the one's complement of the B nibble.
module ex_bcd_nibble
  import ex_pipe_unit_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  input  logic       i_sub,
  output logic [3:0] o_s,
  output logic       o_c
);

  logic [4:0] w_sum;

  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_c};
    o_s   = w_sum[3:0];
    o_c   = w_sum[4];
    if (!i_sub) begin
      if (w_sum > 5'd9) begin
        o_s = w_sum[3:0] + 4'd6;
        o_c = 1'b1;
      end
    end else begin
      // No carry out of the nibble means a decimal borrow occurred
      if (!w_sum[4]) begin
        o_s = w_sum[3:0] - 4'd6;
        o_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_pipe_unit.sv
// Registered, valid/ready handshaked execute unit holding the N/V/Z/C flags,
// with optional nibble-serial decimal ADC/SBC.
module ex_pipe_unit
  import ex_pipe_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 2 * BYTE,
  parameter bit          ENABLE_BCD = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] op_A_i,
  input  logic [DATA_W-1:0] op_B_i,
  input  alu_op_t           alu_op_i,
  input  logic              decimal_i,
  input  logic              set_flags_i,
  input  logic [3:0]        flags_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] alu_res_o,
  output logic [3:0]        flags_o,
  output logic              busy_o
);

  localparam int unsigned NIB   = DATA_W / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned MSB   = DATA_W - 1;

  ex_state_t         r_state;
  ex_state_t         w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_res;
  logic              r_valid;
  logic [3:0]        r_flags;

  logic [DATA_W-1:0] r_bcd_a;
  logic [DATA_W-1:0] r_bcd_b;
  logic [DATA_W-1:0] r_bcd_acc;
  logic              r_bcd_c;
  logic              r_bcd_v;
  logic              r_bcd_sub;

  logic              w_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_bcd_start;
  logic              w_bcd_last;
  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_bin_res;
  logic [3:0]        w_flags_base;
  logic [3:0]        w_flags_op;
  logic [3:0]        w_nib_s;
  logic              w_nib_c;
  logic [DATA_W-1:0] w_bcd_res;

  assign w_accept    = valid_i && w_ready;
  assign w_bcd_start = ENABLE_BCD && decimal_i && is_arith(alu_op_i);
  assign w_bcd_last  = (r_state == BCD) && (r_cnt == CNT_W'(NIB - 1));

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept && w_bcd_start) w_next = BCD;
      BCD:  if (w_bcd_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush_i) w_next = IDLE;
  end

  // FSM: outputs
  always_comb begin
    w_ready = rstn_i && !flush_i && (r_state == IDLE) && (!r_valid || ready_i);
    w_busy  = (r_state == BCD);
  end

  // Binary ALU; flags not touched by the op fall through from the base value
  always_comb begin
    w_b_eff      = (alu_op_i == SBC) ? ~op_B_i : op_B_i;
    w_sum        = {1'b0, op_A_i} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, r_flags[FLAG_C]};
    w_flags_base = set_flags_i ? flags_i : r_flags;
    w_flags_op   = w_flags_base;
    w_bin_res    = '0;
    case (alu_op_i)
      ADC, SBC: begin
        w_bin_res          = w_sum[MSB:0];
        w_flags_op[FLAG_C] = w_sum[DATA_W];
        w_flags_op[FLAG_V] = (op_A_i[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != op_A_i[MSB]);
      end
      AND: w_bin_res = op_A_i & op_B_i;
      ORA: w_bin_res = op_A_i | op_B_i;
      EOR: w_bin_res = op_A_i ^ op_B_i;
      ASL: begin
        w_bin_res          = {op_A_i[MSB-1:0], 1'b0};
        w_flags_op[FLAG_C] = op_A_i[MSB];
      end
      LSR: begin
        w_bin_res          = {1'b0, op_A_i[MSB:1]};
        w_flags_op[FLAG_C] = op_A_i[0];
      end
      ROL: begin
        w_bin_res          = {op_A_i[MSB-1:0], r_flags[FLAG_C]};
        w_flags_op[FLAG_C] = op_A_i[MSB];
      end
      ROR: begin
        w_bin_res          = {r_flags[FLAG_C], op_A_i[MSB:1]};
        w_flags_op[FLAG_C] = op_A_i[0];
      end
      INC: w_bin_res = op_A_i + DATA_W'(1);
      DEC: w_bin_res = op_A_i - DATA_W'(1);
      CMP: begin
        w_bin_res          = op_A_i - op_B_i;
        w_flags_op[FLAG_C] = (op_A_i >= op_B_i);
      end
      BIT:   w_bin_res = op_A_i & op_B_i;
      PASSB: w_bin_res = op_B_i;
      default: w_bin_res = '0;
    endcase
    w_flags_op[FLAG_N] = w_bin_res[MSB];
    w_flags_op[FLAG_Z] = (w_bin_res == '0);
    if (alu_op_i == BIT) begin
      w_flags_op[FLAG_N] = op_B_i[MSB];
      w_flags_op[FLAG_V] = op_B_i[MSB-1];
    end
  end

  // Operands shift right one nibble per cycle; result nibbles enter from the top
  ex_bcd_nibble u_bcd_nibble (
    .i_a   (r_bcd_a[3:0]),
    .i_b   (r_bcd_b[3:0]),
    .i_c   (r_bcd_c),
    .i_sub (r_bcd_sub),
    .o_s   (w_nib_s),
    .o_c   (w_nib_c)
  );

  assign w_bcd_res = {w_nib_s, r_bcd_acc[DATA_W-1:4]};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cnt     <= '0;
      r_res     <= '0;
      r_valid   <= 1'b0;
      r_flags   <= '0;
      r_bcd_a   <= '0;
      r_bcd_b   <= '0;
      r_bcd_acc <= '0;
      r_bcd_c   <= 1'b0;
      r_bcd_v   <= 1'b0;
      r_bcd_sub <= 1'b0;
    end else begin
      if (set_flags_i) r_flags <= flags_i;
      if (flush_i) begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else begin
        if (r_valid && ready_i) r_valid <= 1'b0;
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              if (w_bcd_start) begin
                r_bcd_a   <= op_A_i;
                r_bcd_b   <= w_b_eff;
                r_bcd_c   <= r_flags[FLAG_C];
                r_bcd_v   <= w_flags_op[FLAG_V];
                r_bcd_sub <= (alu_op_i == SBC);
                r_bcd_acc <= '0;
                r_cnt     <= '0;
              end else begin
                r_res   <= w_bin_res;
                r_valid <= 1'b1;
                r_flags <= w_flags_op;
              end
            end
          end
          BCD: begin
            r_bcd_a   <= r_bcd_a >> 4;
            r_bcd_b   <= r_bcd_b >> 4;
            r_bcd_c   <= w_nib_c;
            r_bcd_acc <= w_bcd_res;
            r_cnt     <= r_cnt + 1'b1;
            if (w_bcd_last) begin
              r_res   <= w_bcd_res;
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_flags <= {w_bcd_res[MSB], r_bcd_v, (w_bcd_res == '0), w_nib_c};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ready_o   = w_ready;
  assign busy_o    = w_busy;
  assign valid_o   = r_valid;
  assign alu_res_o = r_res;
  assign flags_o   = r_flags;

endmodule

// File: tb/tb_ex_pipe_unit.sv
// Scoreboard bench for ex_pipe_unit built with DATA_W=8 and decimal mode enabled.
module tb_ex_pipe_unit;
  import ex_pipe_unit_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flags;
  } exp_t;

  typedef struct {
    alu_op_t    op;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid_in;
  logic       ready_o;
  logic [7:0] op_a;
  logic [7:0] op_b;
  alu_op_t    alu_op;
  logic       decimal;
  logic       set_flags;
  logic [3:0] flags_in;
  logic       flush;
  logic       valid_o;
  logic       ready_in;
  logic [7:0] res;
  logic [3:0] flags_o;
  logic       busy;

  exp_t       sb_q[$];
  logic [3:0] exp_flags;
  int         n_checks = 0;
  int         n_err = 0;

  vec_t tbl [10] = '{
    '{CMP, 8'h55, 8'h55}, '{CMP, 8'h00, 8'h01}, '{INC, 8'hFF, 8'h00},
    '{DEC, 8'h00, 8'h00}, '{SBC, 8'h80, 8'h01}, '{ASL, 8'h80, 8'h00},
    '{ROR, 8'h01, 8'h00}, '{BIT, 8'h00, 8'hC0}, '{LSR, 8'h01, 8'h00},
    '{PASSB, 8'h00, 8'h00}
  };

  ex_pipe_unit #(.DATA_W(8), .ENABLE_BCD(1'b1)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .valid_i     (valid_in),
    .ready_o     (ready_o),
    .op_A_i      (op_a),
    .op_B_i      (op_b),
    .alu_op_i    (alu_op),
    .decimal_i   (decimal),
    .set_flags_i (set_flags),
    .flags_i     (flags_in),
    .flush_i     (flush),
    .valid_o     (valid_o),
    .ready_i     (ready_in),
    .alu_res_o   (res),
    .flags_o     (flags_o),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference 8-bit ALU: base supplies untouched flags, cin is the committed carry
  function automatic logic [11:0] model(alu_op_t op, logic [7:0] a, logic [7:0] b,
                                        logic [3:0] base, logic cin);
    logic [7:0]  r;
    logic [7:0]  bb;
    logic [3:0]  o;
    int unsigned s;
    o = base;
    r = 8'h00;
    case (op)
      ADC, SBC: begin
        bb   = (op == SBC) ? ~b : b;
        s    = a + bb + cin;
        r    = s[7:0];
        o[0] = (s > 255);
        o[2] = (a[7] == bb[7]) && (r[7] != a[7]);
      end
      AND:   r = a & b;
      ORA:   r = a | b;
      EOR:   r = a ^ b;
      ASL:   begin r = a << 1; o[0] = a[7]; end
      LSR:   begin r = a >> 1; o[0] = a[0]; end
      ROL:   begin r = {a[6:0], cin}; o[0] = a[7]; end
      ROR:   begin r = {cin, a[7:1]}; o[0] = a[0]; end
      INC:   r = a + 8'd1;
      DEC:   r = a - 8'd1;
      CMP:   begin r = a - b; o[0] = (a >= b); end
      BIT:   r = a & b;
      PASSB: r = b;
      default: r = 8'h00;
    endcase
    o[3] = r[7];
    o[1] = (r == 8'h00);
    if (op == BIT) begin
      o[3] = b[7];
      o[2] = b[6];
    end
    return {r, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one binary op for one cycle; set_flags/flags_in may be preset by caller
  task automatic issue(input alu_op_t op, input logic [7:0] a, input logic [7:0] b);
    logic [11:0] m;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    decimal  = 1'b0;
    valid_in = 1'b1;
    #1;
    chk("issue_ready", 16'(ready_o), 16'h1);
    m = model(op, a, b, set_flags ? flags_in : exp_flags, exp_flags[0]);
    sb_q.push_back('{res: m[11:4], flags: m[3:0]});
    exp_flags = m[3:0];
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    set_flags = 1'b0;
  endtask

  task automatic bcd_op(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [3:0] ef);
    int busy_cnt;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    decimal  = 1'b1;
    valid_in = 1'b1;
    #1;
    chk("bcd_issue_ready", 16'(ready_o), 16'h1);
    sb_q.push_back('{res: er, flags: ef});
    exp_flags = ef;
    tick();
    valid_in = 1'b0;
    decimal  = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 8 && !valid_o; k++) begin
      busy_cnt += int'(busy);
      chk("bcd_ready_low", 16'(ready_o), 16'h0);
      tick();
    end
    chk("bcd_busy_cycles", 16'(busy_cnt), 16'd2);
    chk("bcd_valid", 16'(valid_o), 16'h1);
    chk("bcd_busy_end", 16'(busy), 16'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && valid_o && ready_in) begin
      chk("sb_nonempty", 16'(sb_q.size() != 0), 16'h1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_res", 16'(res), 16'(e.res));
        chk("sb_flags", 16'(flags_o), 16'(e.flags));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  held;
    logic [3:0]  saved;
    logic [11:0] m;
    rstn = 1'b0; valid_in = 1'b0; op_a = '0; op_b = '0; alu_op = ADC;
    decimal = 1'b0; set_flags = 1'b0; flags_in = '0; flush = 1'b0; ready_in = 1'b1;
    exp_flags = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 16'(valid_o), 16'h0);
    chk("rst_res", 16'(res), 16'h0);
    chk("rst_flags", 16'(flags_o), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_ready", 16'(ready_o), 16'h0);
    rstn = 1'b1;
    #1;
    chk("ready_after_rst", 16'(ready_o), 16'h1);

    issue(ADC, 8'h7F, 8'h01);
    chk("adc_ovf_valid", 16'(valid_o), 16'h1);
    chk("adc_ovf_res", 16'(res), 16'h80);
    chk("adc_ovf_flags", 16'(flags_o), 16'hC);

    set_flags = 1'b1; flags_in = 4'b0001;
    tick();
    set_flags = 1'b0;
    exp_flags = 4'b0001;
    issue(ADC, 8'hFF, 8'h00);
    chk("chain1_flags", 16'(flags_o), 16'h3);
    issue(ADC, 8'h00, 8'h00);
    chk("chain2_res", 16'(res), 16'h01);
    chk("chain2_flags", 16'(flags_o), 16'h0);

    set_flags = 1'b1; flags_in = 4'b0111;
    issue(AND, 8'hF0, 8'hC0);
    chk("setflags_merge", 16'(flags_o), 16'hD);

    foreach (tbl[i]) issue(tbl[i].op, tbl[i].a, tbl[i].b);
    for (int unsigned i = 0; i < 28; i++) issue(alu_op_t'(i % 14), 8'($urandom), 8'($urandom));

    tick();
    ready_in = 1'b0;
    issue(EOR, 8'h3C, 8'hFF);
    held = res;
    alu_op = ORA; op_a = 8'h01; op_b = 8'h80; valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", 16'(valid_o), 16'h1);
      chk("hold_res", 16'(res), 16'(held));
      chk("hold_ready", 16'(ready_o), 16'h0);
      tick();
    end
    ready_in = 1'b1;
    #1;
    chk("resume_ready", 16'(ready_o), 16'h1);
    m = model(ORA, 8'h01, 8'h80, exp_flags, exp_flags[0]);
    sb_q.push_back('{res: m[11:4], flags: m[3:0]});
    exp_flags = m[3:0];
    tick();
    valid_in = 1'b0;
    chk("resume_res", 16'(res), 16'h81);

    set_flags = 1'b1; flags_in = 4'b0000;
    tick();
    set_flags = 1'b0;
    exp_flags = 4'b0000;
    bcd_op(ADC, 8'h19, 8'h28, 8'h47, 4'b0000);
    bcd_op(ADC, 8'h99, 8'h01, 8'h00, 4'b0011);
    bcd_op(SBC, 8'h42, 8'h15, 8'h27, 4'b0001);

    tick();
    saved = exp_flags;
    alu_op = ADC; op_a = 8'h12; op_b = 8'h34; decimal = 1'b1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; decimal = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_ready_low", 16'(ready_o), 16'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_valid", 16'(valid_o), 16'h0);
    chk("flush_busy", 16'(busy), 16'h0);
    chk("flush_ready", 16'(ready_o), 16'h1);
    chk("flush_flags", 16'(flags_o), 16'(saved));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_valid", 16'(valid_o), 16'h0);
    end
    alu_op = PASSB; op_b = 8'h77; valid_in = 1'b1; flush = 1'b1;
    #1;
    chk("flush_blocks_accept", 16'(ready_o), 16'h0);
    tick();
    flush = 1'b0; valid_in = 1'b0;
    chk("flush_op_dropped", 16'(valid_o), 16'h0);

    issue(PASSB, 8'h00, 8'h5A);
    chk("pre_rst_valid", 16'(valid_o), 16'h1);
    alu_op = ADC; op_a = 8'h05; op_b = 8'h05; decimal = 1'b1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; decimal = 1'b0;
    chk("pre_rst_busy", 16'(busy), 16'h1);
    rstn = 1'b0;
    tick();
    chk("midrst_valid", 16'(valid_o), 16'h0);
    chk("midrst_res", 16'(res), 16'h0);
    chk("midrst_flags", 16'(flags_o), 16'h0);
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_ready", 16'(ready_o), 16'h0);
    rstn = 1'b1;
    exp_flags = 4'b0000;
    issue(CMP, 8'h10, 8'h20);
    chk("cmp_flags", 16'(flags_o), 16'h8);

    repeat (3) tick();
    chk("sb_drained", 16'(sb_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ex_pipe_unit.md
Name: ex_pipe_unit

Overview:
- Parametrised successor of the CPU execute stage: registered, handshaked execute unit.
- Holds the architectural N/V/Z/C status flags and updates them per operation.
- Optionally performs nibble-serial decimal (BCD) ADC/SBC over several cycles.
- Sits between decode/operand fetch (upstream, valid/ready) and writeback (downstream, valid/ready).

Parameters:
- DATA_W, 2*`BYTE (16): operand/result width; must be a multiple of 4 and at least 8.
- ENABLE_BCD, 0: 1 enables decimal-mode ADC/SBC. The 2A03 build uses 0.
- NIB, DATA_W/4: number of nibbles; derived, not overridable.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, synchronous, active-low
- valid_i  in  1  upstream operation valid
- ready_o  out  1  unit can accept an operation this cycle
- op_A_i  in  DATA_W  operand A
- op_B_i  in  DATA_W  operand B
- alu_op_i  in  alu_op_t  operation select
- decimal_i  in  1  D flag from control; used only when ENABLE_BCD=1
- set_flags_i  in  1  write flags_i into the flag register (PLP/SEC/CLC/CLV)
- flags_i  in  4  {N,V,Z,C} write data
- flush_i  in  1  abort in-flight work and drop the output
- valid_o  out  1  alu_res_o valid
- ready_i  in  1  downstream accepts the result
- alu_res_o  out  DATA_W  registered result
- flags_o  out  4  committed {N,V,Z,C}
- busy_o  out  1  BCD sequence in progress

Behaviour:
- Reset (rstn_i low at a clock edge):
  - valid_o=0, alu_res_o=0, flags_o=0, busy_o=0, state=IDLE, nibble counter=0.
  - ready_o=0 while rstn_i is low.
- FSM states:
  - IDLE: default state.
  - BCD: entered on acceptance when ENABLE_BCD && decimal_i && op is ADC or SBC.
  - Return from BCD to IDLE after nibble NIB-1.
- Accept condition: valid_i && ready_o, where ready_o = rstn_i && state==IDLE && (!valid_o || ready_i).
- Binary ops, 1-cycle latency: on the accept edge, alu_res_o, valid_o=1 and the affected flags are all registered.
- Output hold: alu_res_o/valid_o stay stable until valid_o && ready_i.
  - Back-to-back throughput is 1 op/cycle when ready_i=1.
- Carry source: the carry-in is flags_o.C as committed before the edge, so chained ADC sequences work back-to-back.
- Operations (msb = DATA_W-1). N = res[msb] and Z = (res==0) unless stated otherwise:
  - ADC: res = A+B+C. C = carry out of bit msb. V = (A[msb]==B[msb]) && (res[msb]!=A[msb]).
  - SBC: as ADC with B replaced by ~B.
  - AND/ORA/EOR: bitwise; N, Z only.
  - ASL: C = A[msb], res = A<<1.
  - LSR: C = A[0], res = A>>1.
  - ROL: res = {A[msb-1:0], C}, C = A[msb].
  - ROR: res = {C, A[msb:1]}, C = A[0].
  - INC/DEC: res = A±1, wrapping modulo 2^DATA_W; N, Z only.
  - CMP: res = A-B. C = (A>=B) unsigned; N, Z from res.
  - BIT: res = A&B. Z = (res==0), N = B[msb], V = B[msb-1].
  - PASSB: res = B; N, Z only.
- Flags not affected by an op keep their value.
- set_flags_i: flags_o <= flags_i.
  - If it coincides with an accepted binary op, the bits that op affects take the op's value; the other bits take flags_i.
  - During BCD, set_flags_i is applied immediately, and completion still overwrites N, V, Z, C.
- BCD sequence: one nibble per cycle, LSB nibble first.
  - Per nibble: s = A_n + B'_n + c, where B' = B for ADC and ~B for SBC.
  - ADC: if s > 9, s += 6 and c = 1.
  - SBC: if no carry out of the nibble, s -= 6 and c = 0.
  - Latency: NIB cycles in BCD, then valid_o=1 on the final edge.
  - Completion flags: C = final decimal carry; V = the binary ADC/SBC V; N, Z from the decimal result.
  - busy_o=1 throughout BCD; ready_o=0.
- flush_i (highest priority after reset):
  - Next edge: valid_o=0, state=IDLE, counter=0.
  - An aborted BCD op commits no flags.
  - An op presented with flush_i is not accepted; ready_o is 0 in the flush cycle.
- Reset mid-BCD: identical to the reset values above; no flag commit.

Decomposition:
- Shared package (existing cpu package):
  - alu_op_t extended with ADC, SBC, AND, ORA, EOR, ASL, LSR, ROL, ROR, INC, DEC, CMP, BIT, PASSB.
  - Flag index constants FLAG_N=3, FLAG_V=2, FLAG_Z=1, FLAG_C=0.
  - ex_state_t {IDLE, BCD}.
- One sub-module: ex_bcd_nibble, a combinational 4-bit decimal add/sub with carry in/out, instantiated once and time-multiplexed by the nibble counter.

Test Plan:
- DATA_W=8, C=0: ADC A=0x7F, B=0x01 -> next cycle alu_res_o=0x80, flags N=1 V=1 Z=0 C=0, valid_o=1.
- Back-to-back with C=1 committed: ADC 0xFF+0x00, then ADC 0x00+0x00 on the next cycle.
  - First op -> 0x00, C=1, Z=1.
  - Second op -> 0x01, C=0.
  - Confirms the carry chain at full rate.
- ready_i held 0 for 3 cycles after a result -> alu_res_o/valid_o stable, ready_o=0; op accepted the cycle after ready_i=1.
- ENABLE_BCD=1, DATA_W=8, decimal_i=1, C=0: ADC 0x19+0x28 -> busy_o for 2 cycles, then alu_res_o=0x47, C=0.
  - Also ADC 0x99+0x01 -> 0x00, C=1, Z=1.
- Flush on cycle 1 of ADC-BCD -> valid_o never rises, flags_o unchanged, ready_o=1 on the following cycle.
- Reset asserted mid-BCD with valid_o previously high -> all outputs 0 the next cycle; CMP A=0x10, B=0x20 after reset -> C=0, N=1, Z=0.
